// File: rtl/ram_ex_checker.sv
// ram_ex_checker: fills a memory with an 8-bit LFSR pattern from an upstream
// generator. It then reads every word back and compares the data against a
// local copy of the same LFSR. The first mismatch is latched and all
// mismatches are counted.
//
// Memory handshake: a request (mem_write or mem_read) is accepted in any
// cycle where it is asserted and mem_waitrequest is 0. The request must stay
// asserted with stable address and data until it is accepted. Read data
// returns later as a one-cycle mem_rdvalid pulse per accepted read, in
// request order. Any number of reads may be outstanding.
module ram_ex_checker #(
    parameter int SEED   = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              gen_enable,
    output logic              gen_pause,
    input  logic [7:0]        gen_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic              mem_waitrequest,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_rdvalid,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] err_addr,
    output logic [7:0]        err_exp,
    output logic [7:0]        err_got
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0]        SEED8 = 8'(SEED);
    localparam logic [ADDR_W-1:0] LAST  = '1;

    state_t            state;
    logic [ADDR_W-1:0] wcnt;      // next write address
    logic [ADDR_W:0]   rcnt;      // reads issued; MSB set once all are issued
    logic [ADDR_W-1:0] resp_cnt;  // responses received so far
    logic [7:0]        exp_q;     // expected data for the next response
    logic              issue_rd;
    logic              mismatch;

    // Same feedback taps as the upstream generator (polynomial 0x1D).
    function automatic logic [7:0] lfsr_step(input logic [7:0] q);
        logic [7:0] n;
        n[0] = q[7];
        n[1] = q[0];
        n[2] = q[1] ^ q[7];
        n[3] = q[2] ^ q[7];
        n[4] = q[3] ^ q[7];
        n[5] = q[4];
        n[6] = q[5];
        n[7] = q[6];
        return n;
    endfunction

    assign issue_rd = (state == READ) && !rcnt[ADDR_W];
    assign mismatch = (mem_rdata != exp_q);

    // State machine, counters and first-error capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wcnt      <= '0;
            rcnt      <= '0;
            resp_cnt  <= '0;
            exp_q     <= SEED8;
            err_count <= '0;
            err_addr  <= '0;
            err_exp   <= '0;
            err_got   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= WRITE;
                        wcnt      <= '0;
                        rcnt      <= '0;
                        resp_cnt  <= '0;
                        err_count <= '0;
                        err_addr  <= '0;
                        err_exp   <= '0;
                        err_got   <= '0;
                    end
                end
                WRITE: begin
                    if (!mem_waitrequest) begin
                        wcnt <= wcnt + 1'b1;
                        if (wcnt == LAST) begin
                            state <= READ;
                            exp_q <= SEED8;
                        end
                    end
                end
                READ: begin
                    // Issue and response are independent and may coincide.
                    if (issue_rd && !mem_waitrequest) begin
                        rcnt <= rcnt + 1'b1;
                    end
                    if (mem_rdvalid) begin
                        if (mismatch) begin
                            if (err_count == 16'd0) begin
                                err_addr <= resp_cnt;
                                err_exp  <= exp_q;
                                err_got  <= mem_rdata;
                            end
                            if (err_count != 16'hFFFF) begin
                                err_count <= err_count + 16'd1;
                            end
                        end
                        exp_q    <= lfsr_step(exp_q);
                        resp_cnt <= resp_cnt + 1'b1;
                        if (resp_cnt == LAST) begin
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decoded from the state register. They are forced idle while
    // reset is high, so no request leaks out in the reset cycle.
    always_comb begin
        gen_enable = 1'b0;
        gen_pause  = 1'b1;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        mem_addr   = '0;
        mem_wdata  = gen_data;
        busy       = 1'b0;
        done       = 1'b0;
        pass       = 1'b0;
        if (!reset) begin
            case (state)
                WRITE: begin
                    gen_enable = 1'b1;
                    gen_pause  = mem_waitrequest;
                    mem_write  = 1'b1;
                    mem_addr   = wcnt;
                    busy       = 1'b1;
                end
                READ: begin
                    mem_read = issue_rd;
                    mem_addr = rcnt[ADDR_W-1:0];
                    busy     = 1'b1;
                end
                DONE: begin
                    done = 1'b1;
                    pass = (err_count == 16'd0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_ex_checker.sv
// Bench for ram_ex_checker. It provides a behavioural upstream LFSR and a
// behavioural RAM with optional stalls, read latency, a stuck-bit fault and
// an all-zero read mode.
module tb_ram_ex_checker;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        gen_enable, gen_pause;
    logic [7:0]  gen_data;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_write, mem_read;
    logic        mem_waitrequest;
    logic [7:0]  mem_rdata;
    logic        mem_rdvalid;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [7:0]  err_addr, err_exp, err_got;

    int n_checks = 0;
    int n_fail   = 0;

    // memory model controls
    logic stall_en = 1'b0;
    logic fault_en = 1'b0;
    logic zero_en  = 1'b0;
    logic stray_v  = 1'b0;
    int   lat      = 1;

    int         cyc = 0;
    int         last_w_cyc = 0;
    int         first_r_cyc = -1;
    logic [7:0] gen_q = 8'h20;
    logic       wait_r = 1'b0;
    logic       rv_r = 1'b0;
    logic [7:0] rd_r = 8'h00;
    logic [7:0] ram [DEPTH];
    logic [7:0] wlog [$];
    logic [7:0] alog [$];
    logic [7:0] rq_data [$];
    int         rq_due [$];

    ram_ex_checker #(.SEED(32), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .gen_enable(gen_enable), .gen_pause(gen_pause), .gen_data(gen_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_read(mem_read), .mem_waitrequest(mem_waitrequest),
        .mem_rdata(mem_rdata), .mem_rdvalid(mem_rdvalid),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .err_addr(err_addr), .err_exp(err_exp), .err_got(err_got)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [7:0] model_next(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1D : 8'h00);
    endfunction

    // upstream generator
    assign gen_data = gen_q;
    always @(posedge clk) begin
        if (!gen_enable) gen_q <= 8'h20;
        else if (!gen_pause) gen_q <= model_next(gen_q);
    end

    // RAM model
    assign mem_waitrequest = wait_r;
    assign mem_rdvalid     = rv_r | stray_v;
    assign mem_rdata       = stray_v ? 8'hFF : rd_r;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        wait_r <= stall_en ? ($urandom_range(0, 3) == 0) : 1'b0;
        if (mem_write && !mem_waitrequest) begin
            ram[mem_addr] <= (fault_en && mem_addr == 8'd1) ? (mem_wdata | 8'h08) : mem_wdata;
            wlog.push_back(mem_wdata);
            alog.push_back(mem_addr);
            last_w_cyc <= cyc;
        end
        if (mem_read && first_r_cyc < 0) first_r_cyc <= cyc;
        if (mem_read && !mem_waitrequest) begin
            rq_data.push_back(zero_en ? 8'h00 : ram[mem_addr]);
            rq_due.push_back(cyc + lat - 1);
        end
        rv_r <= 1'b0;
        if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
            rv_r <= 1'b1;
            rd_r <= rq_data[0];
            void'(rq_data.pop_front());
            void'(rq_due.pop_front());
        end
    end

    // scoreboard check
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic begin_run();
        wlog.delete();
        alog.delete();
        first_r_cyc = -1;
        pulse_start();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 5000 && !done; i++) @(negedge clk);
        check("done_reached", {31'd0, done}, 32'd1);
    endtask

    // compare the logged writes against the reference pattern
    task automatic check_writes(input string tag);
        logic [7:0] e;
        int bad;
        e = 8'h20;
        bad = 0;
        for (int i = 0; i < wlog.size(); i++) begin
            if (wlog[i] !== e || alog[i] !== 8'(i)) bad++;
            e = model_next(e);
        end
        check({tag, "_wcount"}, wlog.size(), DEPTH);
        check({tag, "_wseq_bad"}, bad, 0);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_pass", {31'd0, pass}, 0);
        check("rst_wr_rd", {30'd0, mem_write, mem_read}, 0);
        check("rst_gen", {30'd0, gen_enable, gen_pause}, 32'h1);
        check("rst_err", {err_count, err_addr, err_exp}, 0);
        reset = 1'b0;

        // stray responses in IDLE must not count
        @(negedge clk);
        stray_v = 1'b1;
        repeat (3) @(negedge clk);
        stray_v = 1'b0;
        check("idle_stray_err", err_count, 0);

        // ideal RAM
        begin_run();
        wait_done();
        check("ideal_w0", wlog[0], 8'h20);
        check("ideal_w1", wlog[1], 8'h40);
        check("ideal_w2", wlog[2], 8'h80);
        check("ideal_w3", wlog[3], 8'h1D);
        check("ideal_a3", alog[3], 8'd3);
        check_writes("ideal");
        check("ideal_turnaround", first_r_cyc, last_w_cyc + 1);
        check("ideal_pass", {31'd0, pass}, 1);
        check("ideal_errs", err_count, 0);
        check("ideal_busy", {31'd0, busy}, 0);
        repeat (5) @(negedge clk);
        check("done_hold", {30'd0, done, pass}, 32'h3);

        // stuck bit 3 at address 1
        fault_en = 1'b1;
        begin_run();
        wait_done();
        fault_en = 1'b0;
        check("fault_count", err_count, 1);
        check("fault_addr", err_addr, 1);
        check("fault_exp", err_exp, 8'h40);
        check("fault_got", err_got, 8'h48);
        check("fault_pass", {31'd0, pass}, 0);

        // write stalls
        stall_en = 1'b1;
        begin_run();
        wait_done();
        check_writes("stall");
        check("stall_pass", {31'd0, pass}, 1);

        // stalls plus 4-cycle read latency
        lat = 4;
        begin_run();
        wait_done();
        check("lat4_pass", {31'd0, pass}, 1);
        check("lat4_errs", err_count, 0);
        stall_en = 1'b0;
        lat = 1;

        // start during READ is ignored
        begin_run();
        for (int i = 0; i < 2000 && !mem_read; i++) @(negedge clk);
        check("rd_reached", {31'd0, mem_read}, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rdstart_busy", {31'd0, busy}, 1);
        wait_done();
        check("rdstart_wcount", wlog.size(), DEPTH);
        check("rdstart_pass", {31'd0, pass}, 1);

        // reset during WRITE aborts
        begin_run();
        repeat (10) @(negedge clk);
        check("pre_rst_write", {31'd0, mem_write}, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_write", {31'd0, mem_write}, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_gen_en", {31'd0, gen_enable}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {29'd0, mem_write, mem_read, busy}, 0);

        // all reads return zero
        zero_en = 1'b1;
        begin_run();
        wait_done();
        zero_en = 1'b0;
        check("zero_count", err_count, DEPTH);
        check("zero_addr", err_addr, 0);
        check("zero_exp", err_exp, 8'h20);
        check("zero_got", err_got, 8'h00);
        check("zero_pass", {31'd0, pass}, 0);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_ex_checker.md
RAM_EX_CHECKER -- requirements
Module: ram_ex_checker

Interface
REQ-001 The block SHALL take parameter SEED, default 32; its low 8 bits are the pattern start value and SHALL match the seed of the upstream LFSR generator.
REQ-002 The block SHALL take parameter ADDR_W, default 8; the test covers DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have the following ports, clock and reset first:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to begin a test run.
- gen_enable  out  1  upstream LFSR enable; 0 holds the generator at SEED.
- gen_pause  out  1  upstream LFSR pause.
- gen_data  in  8  current upstream LFSR value.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  8  write data.
- mem_write  out  1  write request.
- mem_read  out  1  read request.
- mem_waitrequest  in  1  1 = the request this cycle is not accepted.
- mem_rdata  in  8  read data.
- mem_rdvalid  in  1  read data valid; responses return in request order.
- busy  out  1  a test run is in progress.
- done  out  1  level; the run has completed.
- pass  out  1  done and zero errors.
- err_count  out  16  mismatch count, saturating at 0xFFFF.
- err_addr  out  ADDR_W  index of the first mismatch.
- err_exp  out  8  expected data at the first mismatch.
- err_got  out  8  read data at the first mismatch.

Function
REQ-005 The block SHALL be a state machine with states IDLE, WRITE, READ and DONE.
REQ-006 In IDLE and DONE, start=1 SHALL clear the counters, err_count, done, pass and the err_* registers, and SHALL move to WRITE on the next cycle.
REQ-007 start SHALL be ignored in WRITE and READ.
REQ-008 busy SHALL be 1 exactly in WRITE and READ.
REQ-009 gen_enable SHALL be 1 only in WRITE, so the generator presents SEED on the first WRITE cycle.
REQ-010 In WRITE, mem_write=1, mem_addr=wcnt and mem_wdata=gen_data (combinational) every cycle.
REQ-011 A write SHALL be accepted in any WRITE cycle with mem_waitrequest=0; on acceptance, wcnt increments.
REQ-012 In WRITE, gen_pause SHALL equal mem_waitrequest, so the generator advances exactly once per accepted write.
REQ-013 gen_pause SHALL be 1 outside WRITE.
REQ-014 When the write at wcnt=DEPTH-1 is accepted, the next state SHALL be READ and wcnt SHALL wrap to 0.
REQ-015 In READ, the block SHALL assert mem_read=1 with mem_addr=rcnt while rcnt < DEPTH; rcnt increments per accepted read; mem_read=0 once all DEPTH reads are issued.
REQ-016 The internal expected LFSR SHALL load SEED on entry to READ.
REQ-017 On each mem_rdvalid in READ, the block SHALL compare mem_rdata with the expected value, then advance the expected LFSR with next[0]=q7, next[1]=q0, next[2]=q1^q7, next[3]=q2^q7, next[4]=q3^q7, next[5]=q4, next[6]=q5, next[7]=q6.
REQ-018 On a mismatch, err_count SHALL increment, saturating at 0xFFFF.
REQ-019 On the first mismatch of a run only, the block SHALL latch err_addr = response index, err_exp and err_got.
REQ-020 After the DEPTH-th response, the next state SHALL be DONE.
REQ-021 In DONE, done=1 and pass=(err_count==0); the block holds DONE until start.
REQ-022 A read issue and a response in the same cycle SHALL both be handled.
REQ-023 mem_rdvalid outside READ SHALL be ignored.
REQ-024 The write-to-read turnaround SHALL insert no idle cycle beyond the state change.

Reset
REQ-025 While reset=1: state=IDLE; wcnt, rcnt, response count, err_count, err_addr, err_exp and err_got = 0; busy=done=pass=0; mem_write=mem_read=0; gen_enable=0; gen_pause=1.
REQ-026 A reset mid-run SHALL abort the run with no further memory requests from the next cycle.

Verification
REQ-027 Ideal RAM (waitrequest=0, rdvalid 1 cycle after read), SEED=32, start -> first four writes carry 0x20, 0x40, 0x80, 0x1D at addresses 0-3; done=1, pass=1, err_count=0.
REQ-028 RAM with data bit 3 stuck at 1 at address 1 -> err_count=1, err_addr=1, err_exp=0x40, err_got=0x48, pass=0.
REQ-029 Random waitrequest stalls during WRITE -> the written data sequence is unchanged, with no duplicated or skipped LFSR values.
REQ-030 Stalls plus 4-cycle read latency with up to 4 reads outstanding -> pass=1.
REQ-031 start during READ -> ignored; reset asserted during WRITE -> next cycle mem_write=0, busy=0, gen_enable=0.
REQ-032 All reads return 0x00 -> err_count=DEPTH, err_addr=0, err_exp=0x20.
